// File: rtl/cordic_iq_accumulator.sv
// Lock-in I/Q demodulator placed downstream of cordic_sin_cos.
// Each CE sample multiplies ADC_VALUE by COS (I) and SIN (Q) in stage 1. Stage 2 sums the
// products over a window of WINDOW_LEN+1 samples and publishes one I/Q pair per window.
// Windows repeat back-to-back until STOP, or until START restarts them.
//
// Ports:
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   CE                  sample strobe; SIN/COS/ADC_VALUE are valid and aligned in CE cycles
//   SIN, COS            signed oscillator outputs, DATA_BITS wide
//   ADC_VALUE           signed ADC sample, delay-matched to SIN/COS
//   WINDOW_LEN          window length minus one; latched at START and at each window boundary
//   START, STOP         single-cycle pulses; STOP wins when both are high
//   I_OUT, Q_OUT        signed window sums, held between OUT_VALID pulses
//   OUT_VALID           one-cycle pulse when I_OUT/Q_OUT update
//   BUSY                high while a window is running
module cordic_iq_accumulator #(
    parameter int unsigned DATA_BITS   = 16,
    parameter int unsigned ADC_BITS    = 12,
    parameter int unsigned WINDOW_BITS = 10
) (
    input  logic                                                CLK,
    input  logic                                                RESET_N,
    input  logic                                                CE,
    input  logic signed [DATA_BITS-1:0]                         SIN,
    input  logic signed [DATA_BITS-1:0]                         COS,
    input  logic signed [ADC_BITS-1:0]                          ADC_VALUE,
    input  logic        [WINDOW_BITS-1:0]                       WINDOW_LEN,
    input  logic                                                START,
    input  logic                                                STOP,
    output logic signed [DATA_BITS+ADC_BITS+WINDOW_BITS-1:0]    I_OUT,
    output logic signed [DATA_BITS+ADC_BITS+WINDOW_BITS-1:0]    Q_OUT,
    output logic                                                OUT_VALID,
    output logic                                                BUSY
);

    localparam int unsigned PROD_BITS = DATA_BITS + ADC_BITS;
    localparam int unsigned ACC_BITS  = DATA_BITS + ADC_BITS + WINDOW_BITS;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [WINDOW_BITS-1:0] count_q, count_d;
    logic [WINDOW_BITS-1:0] len_q, len_d;

    logic                        p_valid_q, p_first_q, p_last_q;
    logic signed [PROD_BITS-1:0] p_i_q, p_q_q;
    logic signed [ACC_BITS-1:0]  acc_i_q, acc_q_q;
    logic signed [ACC_BITS-1:0]  i_out_q, q_out_q;
    logic                        out_valid_q;

    logic                        restart;
    logic                        take;
    logic                        acc_en;
    logic signed [PROD_BITS-1:0] adc_ext, sin_ext, cos_ext;
    logic signed [PROD_BITS-1:0] mul_i, mul_q;
    logic signed [ACC_BITS-1:0]  prod_i_ext, prod_q_ext;
    logic signed [ACC_BITS-1:0]  sum_i, sum_q;

    // START with STOP low (re)starts from either state; STOP always wins.
    assign restart = START && !STOP;
    // No sample is taken in a cycle that carries START or STOP.
    assign take    = (state_q == StRun) && CE && !START && !STOP;
    // p_valid is only ever set from RUN, so a concurrent START/STOP means an abort.
    assign acc_en  = p_valid_q && !START && !STOP;

    // Operands are sign-extended to the full product width so the multiply is exact.
    assign adc_ext = {{DATA_BITS{ADC_VALUE[ADC_BITS-1]}}, ADC_VALUE};
    assign sin_ext = {{ADC_BITS{SIN[DATA_BITS-1]}}, SIN};
    assign cos_ext = {{ADC_BITS{COS[DATA_BITS-1]}}, COS};
    assign mul_i   = adc_ext * cos_ext;
    assign mul_q   = adc_ext * sin_ext;

    assign prod_i_ext = {{WINDOW_BITS{p_i_q[PROD_BITS-1]}}, p_i_q};
    assign prod_q_ext = {{WINDOW_BITS{p_q_q[PROD_BITS-1]}}, p_q_q};
    assign sum_i      = p_first_q ? prod_i_ext : acc_i_q + prod_i_ext;
    assign sum_q      = p_first_q ? prod_q_ext : acc_q_q + prod_q_ext;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (restart) state_d = StRun;
            StRun:   if (STOP) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = (state_q == StRun);
    end

    // Sample counter; the window length is re-latched at each boundary so a mid-window
    // WINDOW_LEN change only affects the next window.
    always_comb begin
        count_d = count_q;
        len_d   = len_q;
        if (restart) begin
            count_d = '0;
            len_d   = WINDOW_LEN;
        end else if (take) begin
            if (count_q == len_q) begin
                count_d = '0;
                len_d   = WINDOW_LEN;
            end else begin
                count_d = count_q + {{(WINDOW_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // Stage 1: registered products tagged with window position.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_i_q     <= '0;
            p_q_q     <= '0;
        end else begin
            p_valid_q <= take;
            if (take) begin
                p_first_q <= (count_q == '0);
                p_last_q  <= (count_q == len_q);
                p_i_q     <= mul_i;
                p_q_q     <= mul_q;
            end
        end
    end

    // Stage 2: accumulate and publish at the last sample of each window.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= acc_en && p_last_q;
            if (acc_en) begin
                acc_i_q <= sum_i;
                acc_q_q <= sum_q;
                if (p_last_q) begin
                    i_out_q <= sum_i;
                    q_out_q <= sum_q;
                end
            end
        end
    end

    assign I_OUT     = i_out_q;
    assign Q_OUT     = q_out_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_cordic_iq_accumulator.sv
module tb_cordic_iq_accumulator;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int WB  = 10;
    localparam int ACC = DW + AW + WB;

    logic                  clk;
    logic                  rst_n;
    logic                  ce;
    logic signed [DW-1:0]  sin_v;
    logic signed [DW-1:0]  cos_v;
    logic signed [AW-1:0]  adc;
    logic        [WB-1:0]  wlen;
    logic                  start;
    logic                  stop;
    logic signed [ACC-1:0] i_out;
    logic signed [ACC-1:0] q_out;
    logic                  out_valid;
    logic                  busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a window is a list of captured products summed when it fills up.
    bit     m_run;
    int     m_len;
    longint mq_i[$];
    longint mq_q[$];
    bit     m_fl;
    longint m_fl_i, m_fl_q;
    bit     m_valid;
    longint m_i, m_q;

    cordic_iq_accumulator #(
        .DATA_BITS   (DW),
        .ADC_BITS    (AW),
        .WINDOW_BITS (WB)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .CE         (ce),
        .SIN        (sin_v),
        .COS        (cos_v),
        .ADC_VALUE  (adc),
        .WINDOW_LEN (wlen),
        .START      (start),
        .STOP       (stop),
        .I_OUT      (i_out),
        .Q_OUT      (q_out),
        .OUT_VALID  (out_valid),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_len = 0; m_fl = 0; m_fl_i = 0; m_fl_q = 0;
        m_valid = 0; m_i = 0; m_q = 0;
        mq_i.delete(); mq_q.delete();
    endtask

    // Called at each rising edge with the inputs the DUT is sampling.
    task automatic model_step();
        bit     abort;
        longint si, sq;
        if (!rst_n) begin
            model_reset();
            return;
        end
        abort   = m_run && (start || stop);
        m_valid = m_fl && !abort;
        if (m_valid) begin
            m_i = m_fl_i;
            m_q = m_fl_q;
        end
        m_fl = 0;
        if (start && !stop) begin
            m_run = 1; m_len = int'(wlen);
            mq_i.delete(); mq_q.delete();
        end else if (m_run && stop) begin
            m_run = 0;
            mq_i.delete(); mq_q.delete();
        end else if (m_run && ce) begin
            mq_i.push_back(longint'(adc) * longint'(cos_v));
            mq_q.push_back(longint'(adc) * longint'(sin_v));
            if (mq_i.size() == m_len + 1) begin
                si = 0; sq = 0;
                foreach (mq_i[k]) si += mq_i[k];
                foreach (mq_q[k]) sq += mq_q[k];
                m_fl = 1; m_fl_i = si; m_fl_q = sq;
                m_len = int'(wlen);
                mq_i.delete(); mq_q.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 0; sin_v = 0; cos_v = 0; adc = 0; wlen = 0; start = 0; stop = 0;
        model_reset();
        #2;
        n_assert++; if (i_out !== '0) begin n_fail++; $display("FAIL reset_i: got %0d want 0", i_out); end
        n_assert++; if (q_out !== '0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q_out); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        #10 rst_n = 1'b1;
        tick();
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_dc();
        bit exp_v;
        ce = 1; adc = 100; cos_v = 32767; sin_v = 0; wlen = 3; start = 1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            start = 0;
            if (t == 1) begin
                n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dc_busy: got %b want 1", busy); end
            end
            exp_v = (t >= 6) && ((t - 6) % 4 == 0);
            n_assert++;
            if (out_valid !== exp_v) begin
                n_fail++; $display("FAIL dc_valid t=%0d: got %b want %b", t, out_valid, exp_v);
            end
            if (exp_v) begin
                n_assert++; if (longint'(i_out) !== 64'sd13106800) begin n_fail++; $display("FAIL dc_i: got %0d want 13106800", i_out); end
                n_assert++; if (longint'(q_out) !== 64'sd0) begin n_fail++; $display("FAIL dc_q: got %0d want 0", q_out); end
            end
        end
        do_stop();
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dc_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_extremes();
        int got = 0;
        ce = 1; adc = -12'sd2048; sin_v = -16'sd32768; cos_v = 16'sd32767; wlen = 1023; start = 1;
        for (int t = 1; t <= 1100; t++) begin
            tick();
            start = 0;
            if (out_valid === 1'b1) begin
                got = t;
                break;
            end
        end
        n_assert++; if (got != 1026) begin n_fail++; $display("FAIL ext_latency: got tick %0d want 1026", got); end
        n_assert++; if (longint'(q_out) !== 64'sd68719476736) begin n_fail++; $display("FAIL ext_q: got %0d want 68719476736", q_out); end
        n_assert++; if (longint'(i_out) !== -64'sd68717379584) begin n_fail++; $display("FAIL ext_i: got %0d want -68717379584", i_out); end
        do_stop();
    endtask

    task automatic test_ce_gaps();
        ce = 0; adc = 1; cos_v = 1; sin_v = 2; wlen = 2; start = 1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            start = 0;
            n_assert++;
            if (out_valid !== (t == 11)) begin
                n_fail++; $display("FAIL gap_valid t=%0d: got %b want %b", t, out_valid, (t == 11));
            end
            if (t == 11 || t == 12) begin
                n_assert++; if (longint'(i_out) !== 64'sd3) begin n_fail++; $display("FAIL gap_i t=%0d: got %0d want 3", t, i_out); end
                n_assert++; if (longint'(q_out) !== 64'sd6) begin n_fail++; $display("FAIL gap_q t=%0d: got %0d want 6", t, q_out); end
            end
            ce = (t % 3 == 0);
        end
        ce = 0;
        do_stop();
    endtask

    task automatic test_window_change();
        longint exp_i;
        bit     exp_v;
        ce = 1; cos_v = 1; sin_v = -1; adc = 0; wlen = 3; start = 1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            start = 0;
            exp_v = (t == 6) || (t == 8) || (t == 10);
            exp_i = (t == 6) ? 10 : (t == 8) ? 11 : 15;
            n_assert++;
            if (out_valid !== exp_v) begin
                n_fail++; $display("FAIL wchg_valid t=%0d: got %b want %b", t, out_valid, exp_v);
            end
            if (exp_v) begin
                n_assert++; if (longint'(i_out) !== exp_i) begin n_fail++; $display("FAIL wchg_i t=%0d: got %0d want %0d", t, i_out, exp_i); end
                n_assert++; if (longint'(q_out) !== -exp_i) begin n_fail++; $display("FAIL wchg_q t=%0d: got %0d want %0d", t, q_out, -exp_i); end
            end
            adc = AW'(t);
            if (t == 2) wlen = 1;
        end
        do_stop();
    endtask

    task automatic test_abort_restart();
        ce = 1; adc = 5; cos_v = 1; sin_v = 1; wlen = 3; start = 1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            start = 0;
            stop = (t == 3);
            if (t >= 4) begin
                n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy t=%0d: got %b want 0", t, busy); end
                n_assert++; if (longint'(i_out) !== 64'sd15) begin n_fail++; $display("FAIL abort_i t=%0d: got %0d want 15", t, i_out); end
            end
            n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid t=%0d: got %b want 0", t, out_valid); end
        end
        start = 1; stop = 1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            start = 0; stop = 0;
            n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL startstop_busy t=%0d: got %b want 0", t, busy); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 3000; t++) begin
            tick();
            n_assert++;
            if (out_valid !== m_valid) begin
                n_fail++; $display("FAIL rnd_valid t=%0d: got %b want %b", t, out_valid, m_valid);
            end
            n_assert++;
            if (busy !== m_run) begin
                n_fail++; $display("FAIL rnd_busy t=%0d: got %b want %b", t, busy, m_run);
            end
            n_assert++;
            if (longint'(i_out) !== m_i || longint'(q_out) !== m_q) begin
                n_fail++;
                $display("FAIL rnd_iq t=%0d: got %0d/%0d want %0d/%0d", t, i_out, q_out, m_i, m_q);
            end
            ce    = ($urandom_range(0, 9) < 7);
            sin_v = DW'($urandom());
            cos_v = DW'($urandom());
            adc   = AW'($urandom());
            if ($urandom_range(0, 9) == 0) wlen = WB'($urandom_range(0, 7));
            start = (!m_run && $urandom_range(0, 4) == 0) || ($urandom_range(0, 99) < 2);
            stop  = ($urandom_range(0, 99) < 2);
        end
        start = 0; ce = 0;
        do_stop();
    endtask

    task automatic drive_phase(input int k);
        real ph, s, c;
        ph = 2.0 * 3.14159265358979 * real'(k) / 64.0;
        s  = $sin(ph) * 32767.0;
        c  = $cos(ph) * 32767.0;
        sin_v = DW'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
        cos_v = DW'($rtoi(c >= 0.0 ? c + 0.5 : c - 0.5));
        s  = $sin(ph) * 1000.0;
        adc   = AW'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
    endtask

    task automatic test_real_signal();
        int     got = 0;
        longint qn  = 64'sd16776704000;
        longint tol = 64'sd16776704;
        longint dq, di;
        ce = 1; wlen = 1023; start = 1;
        drive_phase(0);
        for (int t = 1; t <= 1100; t++) begin
            tick();
            start = 0;
            if (out_valid === 1'b1) begin
                got = t;
                break;
            end
            drive_phase(t);
        end
        dq = longint'(q_out) - qn;
        if (dq < 0) dq = -dq;
        di = longint'(i_out);
        if (di < 0) di = -di;
        n_assert++; if (got != 1026) begin n_fail++; $display("FAIL real_latency: got tick %0d want 1026", got); end
        n_assert++; if (dq > tol) begin n_fail++; $display("FAIL real_q: got %0d want %0d +/- %0d", q_out, qn, tol); end
        n_assert++; if (di > tol) begin n_fail++; $display("FAIL real_i: got %0d want 0 +/- %0d", i_out, tol); end
        n_assert++;
        if (longint'(q_out) !== m_q || longint'(i_out) !== m_i) begin
            n_fail++; $display("FAIL real_model: got %0d/%0d want %0d/%0d", i_out, q_out, m_i, m_q);
        end
        for (int t = 0; t < 100; t++) begin
            drive_phase(t);
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_assert++; if (i_out !== '0) begin n_fail++; $display("FAIL midrst_i: got %0d want 0", i_out); end
        n_assert++; if (q_out !== '0) begin n_fail++; $display("FAIL midrst_q: got %0d want 0", q_out); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        #2 rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_assert++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL postrst t=%0d: got valid=%b busy=%b want 0/0", t, out_valid, busy);
            end
        end
        ce = 0;
    endtask

    initial begin
        test_reset();
        test_dc();
        test_extremes();
        test_ce_gaps();
        test_window_change();
        test_abort_restart();
        test_random();
        test_real_signal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_iq_accumulator.md
Name: cordic_iq_accumulator

Overview:
- Downstream consumer of cordic_sin_cos.
- Multiplies each sensor ADC sample by the phase-aligned COS and SIN outputs, then accumulates the products over a programmable window of samples.
- Emits one I/Q pair per window, giving synchronous (lock-in) demodulation of the oscillator signal.
- Windows repeat back-to-back once started; the result feeds the downstream phase/amplitude estimator.

Parameters:
- DATA_BITS, 16: width of signed SIN/COS inputs.
- ADC_BITS, 12: width of signed ADC sample input.
- WINDOW_BITS, 10: width of the window length port. Max window is 2^WINDOW_BITS samples.
- ACC_BITS, DATA_BITS+ADC_BITS+WINDOW_BITS: derived localparam, not overridable. Accumulator/output width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- CE  in  1  sample strobe; SIN, COS and ADC_VALUE are valid and aligned in CE cycles.
- SIN  in  DATA_BITS  signed sine from cordic_sin_cos.
- COS  in  DATA_BITS  signed cosine from cordic_sin_cos.
- ADC_VALUE  in  ADC_BITS  signed ADC sample, already delay-matched to SIN/COS.
- WINDOW_LEN  in  WINDOW_BITS  window length minus 1 (value N gives N+1 samples).
- START  in  1  single-cycle pulse; begin or restart accumulation.
- STOP  in  1  single-cycle pulse; abort and go idle.
- I_OUT  out  ACC_BITS  signed sum of ADC_VALUE*COS over the last completed window.
- Q_OUT  out  ACC_BITS  signed sum of ADC_VALUE*SIN over the last completed window.
- OUT_VALID  out  1  one-cycle pulse when I_OUT/Q_OUT update.
- BUSY  out  1  high while in RUN.

Behaviour:
- States: IDLE, RUN.
- Reset (RESET_N low, async):
  - state IDLE, sample count 0, latched length 0.
  - product-stage valid 0, accumulators 0.
  - I_OUT=0, Q_OUT=0, OUT_VALID=0, BUSY=0.
- IDLE + START (STOP low): next cycle enter RUN, count=0, latch WINDOW_LEN. No samples are taken in the START cycle itself.
- RUN, CE=1, stage 1 (product):
  - register ADC_VALUE*COS and ADC_VALUE*SIN as full-width signed products.
  - tag p_first=(count==0) and p_last=(count==len).
  - set p_valid=1.
  - advance count; at count==len, wrap to 0 and re-latch WINDOW_LEN for the next window.
- RUN, CE=0: p_valid=0. Count holds. Gaps in CE are allowed and do not break the window.
- Stage 2 (accumulate) runs on p_valid, independent of CE:
  - if p_first, acc loads the product; else acc adds the product.
  - if p_last, I_OUT/Q_OUT load the final sum (acc+product) and OUT_VALID pulses on the following cycle.
- Latency: OUT_VALID is high exactly 2 CLK cycles after the CE cycle that captured the last sample of the window.
- Back-to-back windows have no dropped samples: the sample after p_last is p_first of the next window.
- Width: ACC_BITS holds 2^WINDOW_BITS full-scale products without overflow. Sign-extend products; never saturate.
- STOP in RUN: next cycle IDLE; p_valid cleared; any in-flight window is discarded with no OUT_VALID. I_OUT/Q_OUT keep their previous values.
- START in RUN: restart. count=0, re-latch WINDOW_LEN, clear p_valid; the partial window is discarded with no OUT_VALID.
- START and STOP in the same cycle: STOP wins.
- STOP in IDLE: no effect.
- WINDOW_LEN=0: every CE sample is a one-sample window, giving OUT_VALID per sample.
- WINDOW_LEN changes mid-window take effect only at the next window boundary.
- I_OUT/Q_OUT hold their value between OUT_VALID pulses.
- BUSY = (state==RUN).
- Reset asserted mid-window: all state clears immediately; no OUT_VALID is produced.

Test Plan:
- DC test: WINDOW_LEN=3, CE every cycle, ADC=100, COS=32767, SIN=0, START -> OUT_VALID 2 cycles after the 4th sample; I_OUT=13106800, Q_OUT=0; pulse repeats every 4 CE cycles.
- Sign/extremes: WINDOW_LEN=1023, ADC=-2048, SIN=-32768, COS=32767 -> Q_OUT=+68719476736, I_OUT=-68717379584, no wrap.
- CE gaps: WINDOW_LEN=2, CE every 3rd cycle, ADC=1, COS=1, SIN=2 -> I_OUT=3, Q_OUT=6; OUT_VALID 2 cycles after the 3rd CE.
- Window change: WINDOW_LEN 3 -> 1 mid-window -> current window yields a 4-sample sum; subsequent windows yield 2-sample sums.
- Abort/restart: STOP after 2 of 4 samples -> no OUT_VALID, BUSY=0, I_OUT unchanged. Then START with STOP in the same cycle -> stays IDLE.
- Real signal: drive with cordic_sin_cos plus a delayed ADC sinusoid of amplitude 1000 at phase 0, WINDOW_LEN=1023 over an integer number of periods -> Q_OUT≈1000*32767*1024/2 within 0.1%, I_OUT≈0. Then assert RESET_N low mid-window -> all outputs 0 asynchronously.
